fsub_arbiter: RTL and testbench

//  Shares one 2-stage fsub pipeline among N_REQ requesters. Round-robin arbitration, at most one issue per cycle.
//  A tag pipeline matched to the fsub latency routes each result back to its issuer.

---
 rtl/fsub_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fsub_arbiter.sv | 149 ++++++++++++++
 tb/tb_fsub_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fsub_pkg.sv
// fsub_pkg: shared FP types and helpers for the fsub arbiter slice.
//   FP_W      - width of an IEEE single bit pattern
//   FP_SIGN   - sign bit position
//   fp_t      - 32-bit FP bit pattern
//   fp_neg_f  - flips the sign bit (exact negation of any pattern, incl. zeros/NaNs)
package fsub_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned FP_SIGN = 31;

    typedef logic [FP_W-1:0] fp_t;

    function automatic fp_t fp_neg_f(input fp_t x);
        fp_t r;
        r          = x;
        r[FP_SIGN] = ~x[FP_SIGN];
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   ptr_i          - index with highest priority this cycle
//   eligible_i     - per-requester eligibility
//   grant_onehot_o - one-hot grant (all zero if nobody eligible)
//   grant_idx_o    - binary index of the grant (0 when no grant)
// The priority pointer register lives in the parent.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IdxW-1:0] ptr_i,
    input  logic [N-1:0]    eligible_i,
    output logic [N-1:0]    grant_onehot_o,
    output logic [IdxW-1:0] grant_idx_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        found          = 1'b0;
        idx            = 0;
        // Search upward from ptr, wrapping; first eligible index wins.
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr_i) + off) % N;
            if (!found && eligible_i[idx]) begin
                found               = 1'b1;
                grant_onehot_o[idx] = 1'b1;
                grant_idx_o         = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/fsub_arbiter.sv
// fsub_arbiter: shares one fixed-latency fsub pipeline among N_REQ requesters.
//   clk, rst    - clock; synchronous active-high reset
//   req_valid   - requester i has an op
//   req_op      - 0: issue x2 as-is, 1: issue x2 with sign flipped
//   req_x1/x2   - packed operands, requester i at [32*i +: 32]
//   req_ready   - one-hot grant, combinational from req_valid and state
//   fsub_x1/x2  - registered operands to the fsub unit
//   fsub_y      - fsub result
//   resp_valid  - one-hot one-cycle result pulse per requester
//   resp_y      - result, valid when |resp_valid
//   busy        - any op in flight or a response being presented
// A tag pipe of FSUB_LAT+1 stages tracks which requester owns each result; it
// never stalls because the fsub has no stall either.
module fsub_arbiter
    import fsub_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned FSUB_LAT = 2,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [FP_W*N_REQ-1:0] req_x1,
    input  logic [FP_W*N_REQ-1:0] req_x2,
    output logic [N_REQ-1:0]      req_ready,
    output fp_t                   fsub_x1,
    output fp_t                   fsub_x2,
    input  fp_t                   fsub_y,
    output logic [N_REQ-1:0]      resp_valid,
    output fp_t                   resp_y,
    output logic                  busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);
    localparam int unsigned TagN = FSUB_LAT + 1;

    logic [IdxW-1:0]            ptr_q, ptr_d;
    fp_t                        fsub_x1_q, fsub_x1_d;
    fp_t                        fsub_x2_q, fsub_x2_d;
    logic [TagN-1:0]            tag_v_q, tag_v_d;
    logic [TagN-1:0][IdxW-1:0]  tag_id_q, tag_id_d;
    logic [N_REQ-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]           resp_valid_q, resp_valid_d;
    fp_t                        resp_y_q, resp_y_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant_onehot;
    logic [IdxW-1:0]  grant_idx;
    logic             hs;
    logic             retire_v;
    logic [IdxW-1:0]  retire_id;
    fp_t              sel_x1;
    fp_t              sel_x2;
    logic             sel_op;

    // Eligibility ignores a retire landing on the same edge: conservative by design.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CntW'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .ptr_i          (ptr_q),
        .eligible_i     (eligible),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx)
    );

    // No grants while reset is asserted so nothing handshakes into a clearing pipe.
    assign req_ready = rst ? '0 : grant_onehot;
    assign hs        = |req_ready;

    assign sel_x1 = req_x1[FP_W*grant_idx +: FP_W];
    assign sel_x2 = req_x2[FP_W*grant_idx +: FP_W];
    assign sel_op = req_op[grant_idx];

    assign retire_v  = tag_v_q[TagN-1];
    assign retire_id = tag_id_q[TagN-1];

    always_comb begin
        ptr_d        = ptr_q;
        fsub_x1_d    = fsub_x1_q;
        fsub_x2_d    = fsub_x2_q;
        resp_valid_d = '0;
        resp_y_d     = resp_y_q;
        cnt_d        = cnt_q;

        // Tag pipe shifts every cycle; slot 0 carries this cycle's issue (if any).
        tag_v_d  = {tag_v_q[TagN-2:0], hs};
        tag_id_d = {tag_id_q[TagN-2:0], grant_idx};

        if (hs) begin
            ptr_d     = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
            fsub_x1_d = sel_x1;
            fsub_x2_d = sel_op ? fp_neg_f(sel_x2) : sel_x2;
        end

        if (retire_v) begin
            resp_valid_d = N_REQ'(1) << retire_id;
            resp_y_d     = fsub_y;
        end

        for (int i = 0; i < N_REQ; i++) begin
            unique case ({req_ready[i], retire_v && (retire_id == IdxW'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // The fsub itself is not reset; its stale output is harmless because the
    // cleared tag pipe keeps anything from retiring until a new op arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            fsub_x1_q    <= '0;
            fsub_x2_q    <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_y_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            fsub_x1_q    <= fsub_x1_d;
            fsub_x2_q    <= fsub_x2_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
        end
    end

    assign fsub_x1    = fsub_x1_q;
    assign fsub_x2    = fsub_x2_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign busy       = (|tag_v_q) | (|resp_valid_q);

endmodule

// File: tb/tb_fsub_arbiter.sv
// Bench for fsub_arbiter with a 2-stage behavioural fsub stand-in.
// The stand-in computes the integer difference of the bit patterns; the arbiter
// only routes bits, so any deterministic function of (x1, x2) serves.
module tb_fsub_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [3:0]  exp_ready;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_op;
    logic [127:0]  req_x1;
    logic [127:0]  req_x2;
    logic [3:0]    req_ready;
    logic [31:0]   fsub_x1;
    logic [31:0]   fsub_x2;
    logic [31:0]   fsub_y;
    logic [3:0]    resp_valid;
    logic [31:0]   resp_y;
    logic          busy;

    logic [31:0]   fs1, fs2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic [2:0]    m_v;
    logic [1:0]    m_id [3];
    logic [31:0]   m_y  [3];
    logic [3:0]    exp_rv;
    logic [31:0]   exp_ry;
    logic [31:0]   exp_fx1;
    logic [31:0]   exp_fx2;

    vec_t tbl[$];

    fsub_arbiter #(
        .N_REQ    (4),
        .FSUB_LAT (2),
        .MAX_OUT  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_ready  (req_ready),
        .fsub_x1    (fsub_x1),
        .fsub_x2    (fsub_x2),
        .fsub_y     (fsub_y),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        fs1 <= fsub_x1 - fsub_x2;
        fs2 <= fs1;
    end
    assign fsub_y = fs2;

    function automatic vec_t mk(input logic r, input logic [3:0] va, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] er);
        vec_t v;
        v.rst = r; v.valid = va; v.op = op; v.x1 = a; v.x2 = b; v.exp_ready = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        int          idx;
        logic [31:0] xa, xb;
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        req_op    = v.op;
        for (int i = 0; i < 4; i++) begin
            req_x1[32*i +: 32] = v.x1 + 32'(i * 16);
            req_x2[32*i +: 32] = v.x2;
        end
        #1;
        check("req_ready", 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        if (v.rst) begin
            m_v = '0; exp_rv = '0; exp_ry = '0; exp_fx1 = '0; exp_fx2 = '0;
        end else begin
            exp_rv = m_v[2] ? (4'b0001 << m_id[2]) : 4'b0000;
            if (m_v[2]) exp_ry = m_y[2];
            m_v[2] = m_v[1]; m_id[2] = m_id[1]; m_y[2] = m_y[1];
            m_v[1] = m_v[0]; m_id[1] = m_id[0]; m_y[1] = m_y[0];
            m_v[0] = (v.exp_ready != 4'b0000);
            if (m_v[0]) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (v.exp_ready[i]) idx = i;
                xa      = v.x1 + 32'(idx * 16);
                xb      = v.op[idx] ? {~v.x2[31], v.x2[30:0]} : v.x2;
                exp_fx1 = xa;
                exp_fx2 = xb;
                m_id[0] = 2'(idx);
                m_y[0]  = xa - xb;
            end
        end
        #1;
        cyc++;
        check("fsub_x1", fsub_x1, exp_fx1);
        check("fsub_x2", fsub_x2, exp_fx2);
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("resp_y", resp_y, exp_ry);
        check("busy", 32'(busy), 32'((|m_v) | (|exp_rv)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; req_x1 = '0; req_x2 = '0;
        m_v = '0; exp_rv = '0; exp_ry = '0; exp_fx1 = '0; exp_fx2 = '0;
        for (int i = 0; i < 3; i++) begin m_id[i] = '0; m_y[i] = '0; end

        // Reset, including valid requests which must not be granted.
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h0, 32'h0, 32'h0, 4'h0));
        // Fairness: all valid for 8 cycles from ptr=0.
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0000, 32'h3F80_0000, 4'b0001));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0100, 32'h3F80_0000, 4'b0010));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0200, 32'h3F80_0000, 4'b0100));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0300, 32'h3F80_0000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0400, 32'h3F80_0000, 4'b0001));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0500, 32'h3F80_0000, 4'b0010));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0600, 32'h3F80_0000, 4'b0100));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 32'h4100_0700, 32'h3F80_0000, 4'b1000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0));
        // Single op from req0; response 3 cycles later, busy drops after.
        tbl.push_back(mk(1'b0, 4'h1, 4'h0, 32'h3F80_0000, 32'h3F80_0000, 4'b0001));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0));
        // Wrap: grant 2 -> ptr 3; {0,3} valid grants 3 then 0; ptr then at 1.
        tbl.push_back(mk(1'b0, 4'b0100, 4'h0, 32'h4200_0000, 32'h4000_0000, 4'b0100));
        tbl.push_back(mk(1'b0, 4'b1001, 4'h0, 32'h4200_1000, 32'h4000_0000, 4'b1000));
        tbl.push_back(mk(1'b0, 4'b1001, 4'h0, 32'h4200_2000, 32'h4000_0000, 4'b0001));
        tbl.push_back(mk(1'b0, 4'b1111, 4'h0, 32'h4200_3000, 32'h4000_0000, 4'b0010));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0));

        foreach (tbl[n]) step(tbl[n]);

        // op=1 sign flip on req1 (ptr=2, so req1 wins after wrapping).
        step(mk(1'b0, 4'b0010, 4'b0010, 32'h4040_0000, 32'h4000_0000, 4'b0010));
        check("op1_flip_pos", fsub_x2, 32'hC000_0000);
        step(mk(1'b0, 4'b0010, 4'b0010, 32'h4040_0000, 32'h8000_0000, 4'b0010));
        check("op1_flip_negzero", fsub_x2, 32'h0000_0000);
        idle(4);

        // MAX_OUT limit: req2 alone; slot freed at the 1st retire edge is used one cycle later.
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_0000, 32'h3F00_0000, 4'b0100));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_1000, 32'h3F00_0000, 4'b0100));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_2000, 32'h3F00_0000, 4'b0000));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_3000, 32'h3F00_0000, 4'b0000));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_4000, 32'h3F00_0000, 4'b0100));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4300_5000, 32'h3F00_0000, 4'b0100));
        idle(4);

        // Reset mid-flight: 3 ops in flight are dropped; ptr and counters cleared.
        step(mk(1'b0, 4'b0010, 4'h0, 32'h4400_0000, 32'h3E00_0000, 4'b0010));
        step(mk(1'b0, 4'b0010, 4'h0, 32'h4400_1000, 32'h3E00_0000, 4'b0010));
        step(mk(1'b0, 4'b0100, 4'h0, 32'h4400_2000, 32'h3E00_0000, 4'b0100));
        step(mk(1'b1, 4'b1111, 4'h0, 32'h4400_3000, 32'h3E00_0000, 4'b0000));
        check("busy_after_rst", 32'(busy), 32'h0);
        idle(1);
        step(mk(1'b0, 4'b1111, 4'h0, 32'h4500_0000, 32'h3D00_0000, 4'b0001));
        step(mk(1'b0, 4'b0010, 4'h0, 32'h4500_1000, 32'h3D00_0000, 4'b0010));
        step(mk(1'b0, 4'b0010, 4'h0, 32'h4500_2000, 32'h3D00_0000, 4'b0010));
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
